// File: rtl/fp_div.sv
`default_nettype none
// fp_div -- iterative IEEE-754 binary32 divider (restoring, one quotient bit per cycle), fixed 32-cycle frame.
// rev 1.0
module fp_div (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic [31:0] value1,
  input  logic [31:0] value2,
  output logic [31:0] result
);

  typedef enum logic [2:0] {
    S_LOAD  = 3'd0,
    S_DIV   = 3'd1,
    S_NORM  = 3'd2,
    S_ROUND = 3'd3,
    S_WRITE = 3'd4
  } state_t;

  state_t             state, state_nx;
  logic [4:0]         cnt;
  logic [23:0]        divisor;
  logic [25:0]        rem;
  logic [26:0]        quo;
  logic [22:0]        mant;
  logic signed [9:0]  exp;
  logic               sign;
  logic               special;
  logic [31:0]        special_val;

  logic [7:0]  e1, e2;
  logic [22:0] f1, f2;
  logic        s_in;
  logic        zero1, zero2, inf1, inf2, nan1, nan2;
  logic        sp_hit;
  logic [31:0] sp_val;

  assign e1    = value1[30:23];
  assign e2    = value2[30:23];
  assign f1    = value1[22:0];
  assign f2    = value2[22:0];
  assign s_in  = value1[31] ^ value2[31];
  assign zero1 = (e1 == 8'h00);
  assign zero2 = (e2 == 8'h00);
  assign inf1  = (e1 == 8'hFF) && (f1 == 23'd0);
  assign inf2  = (e2 == 8'hFF) && (f2 == 23'd0);
  assign nan1  = (e1 == 8'hFF) && (f1 != 23'd0);
  assign nan2  = (e2 == 8'hFF) && (f2 != 23'd0);

  // Special-case resolution in priority order; subnormals already count as zero.
  always_comb begin
    sp_hit = 1'b1;
    sp_val = 32'h7FC0_0000;
    if (nan1 || nan2 || (zero1 && zero2) || (inf1 && inf2))
      sp_val = 32'h7FC0_0000;
    else if (inf1)
      sp_val = {s_in, 8'hFF, 23'd0};
    else if (inf2)
      sp_val = {s_in, 31'd0};
    else if (zero2)
      sp_val = {s_in, 8'hFF, 23'd0};
    else if (zero1)
      sp_val = {s_in, 31'd0};
    else
      sp_hit = 1'b0;
  end

  logic        ge;
  logic [25:0] diff;
  logic [25:0] rem_sel;
  assign ge      = (rem >= {2'b00, divisor});
  assign diff    = rem - {2'b00, divisor};
  assign rem_sel = ge ? diff : rem;

  logic        sticky;
  logic        round_up;
  logic [24:0] rnd_sum;
  assign sticky   = quo[0] | (rem != 26'd0);
  assign round_up = quo[2] & (quo[1] | sticky | quo[3]);
  assign rnd_sum  = {1'b0, quo[26:3]} + {24'd0, round_up};

  always_comb begin
    state_nx = state;
    case (state)
      S_LOAD:  state_nx = S_DIV;
      S_DIV:   if (cnt == 5'd26) state_nx = S_NORM;
      S_NORM:  state_nx = S_ROUND;
      S_ROUND: state_nx = S_WRITE;
      S_WRITE: if (cnt == 5'd1) state_nx = S_LOAD;
      default: state_nx = S_LOAD;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state       <= S_LOAD;
      cnt         <= 5'd0;
      divisor     <= 24'd0;
      rem         <= 26'd0;
      quo         <= 27'd0;
      mant        <= 23'd0;
      exp         <= 10'sd0;
      sign        <= 1'b0;
      special     <= 1'b0;
      special_val <= 32'd0;
      result      <= 32'd0;
    end else begin
      state <= state_nx;
      case (state)
        S_LOAD: begin
          cnt         <= 5'd0;
          rem         <= {3'b001, f1};
          divisor     <= {1'b1, f2};
          quo         <= 27'd0;
          exp         <= $signed({2'b00, e1}) - $signed({2'b00, e2}) + 10'sd127;
          sign        <= s_in;
          special     <= sp_hit;
          special_val <= sp_val;
        end
        S_DIV: begin
          cnt <= (cnt == 5'd26) ? 5'd0 : cnt + 5'd1;
          quo <= {quo[25:0], ge};
          rem <= {rem_sel[24:0], 1'b0};
        end
        S_NORM: begin
          if (!quo[26]) begin
            quo <= {quo[25:0], 1'b0};
            exp <= exp - 10'sd1;
          end
        end
        S_ROUND: begin
          cnt <= 5'd0;
          if (rnd_sum[24]) begin
            mant <= rnd_sum[23:1];
            exp  <= exp + 10'sd1;
          end else begin
            mant <= rnd_sum[22:0];
          end
        end
        S_WRITE: begin
          cnt <= cnt + 5'd1;
          if (cnt == 5'd1) begin
            if (special)
              result <= special_val;
            else if (exp > 10'sd254)
              result <= {sign, 8'hFF, 23'd0};
            else if (exp < 10'sd1)
              result <= {sign, 31'd0};
            else
              result <= {sign, exp[7:0], mant};
          end
        end
        default: cnt <= 5'd0;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fp_div.sv
`default_nettype none
// tb_fp_div -- scoreboard bench for fp_div against an integer-arithmetic division reference.
module tb_fp_div;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  wire  [31:0] res;

  always #5 clk = ~clk;

  fp_div dut (
    .aclk    (clk),
    .aresetn (rst_n),
    .value1  (a),
    .value2  (b),
    .result  (res)
  );

  int     n_cmp = 0;
  int     n_bad = 0;
  longint cyc   = 0;

  typedef struct {
    logic [31:0] expv;
    longint      due;
    string       tag;
  } item_t;

  item_t sb[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Reference: correctly rounded quotient from exact integer division.
  function automatic logic [31:0] ref_div(input logic [31:0] x, input logic [31:0] y);
    logic   s;
    int     e1, e2, e;
    longint m1, m2, num, qq, r, mant, low;
    bit     z1, z2, i1, i2, n1, n2;
    s  = x[31] ^ y[31];
    e1 = int'(x[30:23]);
    e2 = int'(y[30:23]);
    z1 = (e1 == 0);
    z2 = (e2 == 0);
    i1 = (e1 == 255) && (x[22:0] == 0);
    i2 = (e2 == 255) && (y[22:0] == 0);
    n1 = (e1 == 255) && (x[22:0] != 0);
    n2 = (e2 == 255) && (y[22:0] != 0);
    if (n1 || n2 || (z1 && z2) || (i1 && i2)) return 32'h7FC0_0000;
    if (i1) return {s, 8'hFF, 23'd0};
    if (i2) return {s, 31'd0};
    if (z2) return {s, 8'hFF, 23'd0};
    if (z1) return {s, 31'd0};
    m1 = longint'(x[22:0]) + (64'sd1 <<< 23);
    m2 = longint'(y[22:0]) + (64'sd1 <<< 23);
    e  = e1 - e2 + 127;
    if (m1 < m2) begin
      num = m1 <<< 27;
      e   = e - 1;
    end else begin
      num = m1 <<< 26;
    end
    qq   = num / m2;
    r    = num % m2;
    mant = qq >>> 3;
    low  = qq % 8;
    if (low > 4 || (low == 4 && (r != 0 || (mant % 2) == 1))) mant = mant + 1;
    if (mant == (64'sd1 <<< 24)) begin
      mant = mant >>> 1;
      e    = e + 1;
    end
    if (e >= 255) return {s, 8'hFF, 23'd0};
    if (e <= 0)   return {s, 31'd0};
    return {s, e[7:0], mant[22:0]};
  endfunction

  function automatic logic [31:0] rnd_fp();
    int          k;
    logic [31:0] v;
    k = int'($urandom_range(0, 19));
    v = $urandom;
    if (k == 0)      v[30:23] = 8'hFF;
    else if (k == 1) v[30:0]  = 31'd0;
    else if (k == 2) v[30:23] = 8'h00;
    else if (k == 3) v[22:0]  = 23'd0;
    else if (k >= 6) v[30:23] = 8'($urandom_range(100, 154));
    return v;
  endfunction

  task automatic apply(input logic [31:0] x, input logic [31:0] y, input logic [31:0] e,
                       input string tag, input int hold);
    @(negedge clk);
    a = x;
    b = y;
    sb.push_back('{e, cyc + 64, tag});
    repeat (hold) @(negedge clk);
  endtask

  // Monitor: retires scoreboard entries when due and checks write periodicity.
  logic [31:0] prev;
  longint      last_chg;
  bit          chg_ok;
  initial begin
    item_t it;
    prev     = 32'd0;
    last_chg = 0;
    chg_ok   = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chg_ok = 1'b0;
        prev   = res;
        continue;
      end
      if (res !== prev) begin
        if (chg_ok) check("write_period", 32'((cyc - last_chg) % 32), 32'd0);
        last_chg = cyc;
        chg_ok   = 1'b1;
        prev     = res;
      end
      while (sb.size() > 0 && sb[0].due <= cyc) begin
        it = sb.pop_front();
        check(it.tag, res, it.expv);
      end
    end
  end

  logic [31:0] dir [13][3] = '{
    '{32'h3FC0_0000, 32'h3FC0_0000, 32'h3F80_0000},
    '{32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAB},
    '{32'hC060_0000, 32'h4020_0000, 32'hBFB3_3333},
    '{32'h3F80_0000, 32'h0000_0000, 32'h7F80_0000},
    '{32'h0000_0000, 32'h0000_0000, 32'h7FC0_0000},
    '{32'h7F80_0000, 32'h7F80_0000, 32'h7FC0_0000},
    '{32'h7FC0_0000, 32'h3F80_0000, 32'h7FC0_0000},
    '{32'h7F7F_FFFF, 32'h3E80_0000, 32'h7F80_0000},
    '{32'h0080_0000, 32'h4000_0000, 32'h0000_0000},
    '{32'h8000_0000, 32'h3F80_0000, 32'h8000_0000},
    '{32'hFF80_0000, 32'h4000_0000, 32'hFF80_0000},
    '{32'h4000_0000, 32'hFF80_0000, 32'h8000_0000},
    '{32'h0000_0001, 32'hBF80_0000, 32'h8000_0000}
  };

  initial begin
    logic [31:0] x, y;
    int          guard;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_value", res, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 13; i++)
      apply(dir[i][0], dir[i][1], dir[i][2], $sformatf("dir%0d", i), 80);

    // Asynchronous reset in the middle of a computation.
    @(negedge clk);
    a = 32'h3F80_0000;
    b = 32'h4040_0000;
    repeat (40) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check("reset_mid", res, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    apply(32'h3FC0_0000, 32'h3FC0_0000, 32'h3F80_0000, "post_reset", 80);

    apply(32'h4049_0FDB, 32'h402D_F854, ref_div(32'h4049_0FDB, 32'h402D_F854), "slow0", 500);
    apply(32'hC2C8_0000, 32'h4120_0000, 32'hC120_0000, "slow1", 500);

    for (int i = 0; i < 120; i++) begin
      x = rnd_fp();
      y = rnd_fp();
      apply(x, y, ref_div(x, y), $sformatf("rand %h/%h", x, y), 80);
    end

    guard = 0;
    while (sb.size() > 0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (sb.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
